// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the step-driven register file controller.
//   - DATA_W_DEF / ADDR_W_DEF : default data width and pointer width
//   - state_t                 : controller FSM state encoding
package regfile_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_READ    = 2'd2,
        S_ADVANCE = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_mem.sv
// regfile_mem
//   DEPTH x DATA_W storage: asynchronous read, synchronous write,
//   asynchronous clear of every entry while reset is low.
//   Ports:
//     clk, reset     : clock, asynchronous active-low reset
//     we             : write enable (one entry per asserted cycle)
//     addr           : shared read/write address
//     wdata          : write data
//     rdata          : combinational read of mem[addr]
module regfile_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/regfile_step_ctrl.sv
// regfile_step_ctrl
//   Steps through a register file one access per debounced 'step' pulse.
//   Each accepted step performs one write (wr_mode=1) or read (wr_mode=0)
//   at ptr, then advances ptr. A step takes three cycles end to end.
//   Ports:
//     clk, reset        : clock, asynchronous active-low reset
//     step, clr         : one-shot request pulses (access / pointer clear)
//     wr_mode, sw_data  : access type and write data, sampled with step
//     ptr               : current register pointer
//     rd_data           : last read value, held until the next read
//     rd_valid, wr_done : 1-cycle completion pulses
//     wrap              : 1-cycle pulse when ptr rolls from DEPTH-1 to 0
//     busy              : high while an access is in flight
//     overrun           : sticky, a step arrived while busy
//     dbg_state         : raw FSM state for observation
//   Handshake: step is accepted only when busy=0 at the sampling edge; a
//   step seen while busy=1 is dropped and flagged on overrun. Completion is
//   signalled by exactly one wr_done or rd_valid pulse, 3 cycles after step.
module regfile_step_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic              clr,
    input  logic              wr_mode,
    input  logic [DATA_W-1:0] sw_data,
    output logic [ADDR_W-1:0] ptr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              wr_done,
    output logic              wrap,
    output logic              busy,
    output logic              overrun,
    output logic [1:0]        dbg_state
);

    state_t            state;
    state_t            next_state;
    logic              armed;      // low only until the first edge after reset
    logic              step_ok;
    logic              clr_ok;
    logic              clr_pend;   // clr seen mid-access, applied in ADVANCE
    logic              cap_wr;
    logic [DATA_W-1:0] cap_data;
    logic [DATA_W-1:0] mem_rdata;

    assign step_ok   = step & armed;
    assign clr_ok    = clr & armed;
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    regfile_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (state == S_WRITE),
        .addr  (ptr),
        .wdata (cap_data),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // clr beats step in IDLE
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (step_ok && !clr_ok) next_state = wr_mode ? S_WRITE : S_READ;
            S_WRITE:   next_state = S_ADVANCE;
            S_READ:    next_state = S_ADVANCE;
            S_ADVANCE: next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed    <= 1'b0;
            ptr      <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_done  <= 1'b0;
            wrap     <= 1'b0;
            overrun  <= 1'b0;
            clr_pend <= 1'b0;
            cap_wr   <= 1'b0;
            cap_data <= '0;
        end else begin
            armed    <= 1'b1;
            rd_valid <= 1'b0;
            wr_done  <= 1'b0;
            wrap     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clr_ok) begin
                        ptr     <= '0;
                        overrun <= 1'b0;
                    end else if (step_ok) begin
                        cap_wr   <= wr_mode;
                        cap_data <= sw_data;
                    end
                end
                S_READ: rd_data <= mem_rdata;
                S_ADVANCE: begin
                    // a clr that arrived during the access redirects ptr to 0
                    if (clr_pend || clr_ok) begin
                        ptr <= '0;
                    end else begin
                        ptr  <= ptr + 1'b1;
                        wrap <= &ptr;
                    end
                    clr_pend <= 1'b0;
                    wr_done  <= cap_wr;
                    rd_valid <= ~cap_wr;
                end
                default: ;
            endcase
            if (busy) begin
                if (clr_ok)       overrun <= 1'b0;
                else if (step_ok) overrun <= 1'b1;
                if (clr_ok && state != S_ADVANCE) clr_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_step_ctrl.sv
module tb_regfile_step_ctrl;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int EW = 1 + 1 + AW + DW;  // {is_read, wrap, ptr_after, data}

  logic clk = 1'b0;
  logic reset;
  logic step, clr, wr_mode;
  logic [DW-1:0] sw_data;
  logic [AW-1:0] ptr;
  logic [DW-1:0] rd_data;
  logic rd_valid, wr_done, wrap, busy, overrun;
  logic [1:0] dbg_state;

  regfile_step_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .step(step), .clr(clr), .wr_mode(wr_mode),
    .sw_data(sw_data), .ptr(ptr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_done(wr_done), .wrap(wrap), .busy(busy), .overrun(overrun),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  int due_q[$];

  // reference model: array memory, pointer, sticky flag, accept window
  logic [DW-1:0] m_mem [DEPTH];
  int m_ptr;
  logic m_ovr;
  int edge_n;
  int free_at;
  bit first_edge;

  int pops = 0;
  int wrap_cnt = 0;
  logic [DW-1:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_ptr = 0;
    m_ovr = 1'b0;
    edge_n = 0;
    free_at = 0;
    first_edge = 1'b1;
  endtask

  // what the spec says happens on one clock edge given the sampled inputs
  task automatic model_edge(input logic s, input logic c, input logic w, input logic [DW-1:0] d);
    bit idle;
    logic [EW-1:0] e;
    int addr;
    edge_n++;
    if (first_edge) begin
      first_edge = 1'b0;
      return;
    end
    idle = (edge_n >= free_at);
    if (c) begin
      m_ovr = 1'b0;
      m_ptr = 0;
      if (!idle && exp_q.size() > 0) begin
        e = exp_q[exp_q.size()-1];
        e[DW+AW] = 1'b0;
        e[DW +: AW] = '0;
        exp_q[exp_q.size()-1] = e;
      end
    end else if (s) begin
      if (idle) begin
        addr = m_ptr;
        m_ptr = (addr + 1) % DEPTH;
        e = '0;
        e[EW-1] = ~w;
        e[DW+AW] = (addr == DEPTH - 1);
        e[DW +: AW] = AW'(m_ptr);
        if (w) m_mem[addr] = d;
        else   e[DW-1:0] = m_mem[addr];
        exp_q.push_back(e);
        due_q.push_back(edge_n + 2);
        free_at = edge_n + 3;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  // driver: called at posedge+1, presents inputs for the next edge
  task automatic tick(input logic s, input logic c, input logic w, input logic [DW-1:0] d);
    step = s; clr = c; wr_mode = w; sw_data = d;
    @(posedge clk);
    model_edge(s, c, w, d);
    #1;
    step = 1'b0; clr = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_access(input logic w, input logic [DW-1:0] d);
    tick(1'b1, 1'b0, w, d);
    idle_ticks(3);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    exp_q.delete();
    due_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int due;
    if (wr_done || rd_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_pulse actual=wr%0b/rd%0b required=none t=%0t", wr_done, rd_valid, $time);
      end else begin
        e = exp_q.pop_front();
        due = due_q.pop_front();
        pops++;
        chk("pulse_kind", {31'd0, rd_valid}, {31'd0, e[EW-1]});
        chk("pulse_excl", {31'd0, wr_done & rd_valid}, 32'd0);
        chk("wrap", {31'd0, wrap}, {31'd0, e[DW+AW]});
        chk("ptr_after", 32'(ptr), 32'(e[DW +: AW]));
        chk("latency_edge", edge_n, due);
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        if (e[EW-1]) begin
          chk("rd_data", 32'(rd_data), 32'(e[DW-1:0]));
          last_rd = rd_data;
        end
      end
    end else if (wrap) begin
      n_chk++; n_err++;
      $display("FAIL stray_wrap actual=1 required=0 t=%0t", $time);
    end
    if (wrap) wrap_cnt++;
  end

  initial begin
    int p0;
    step = 1'b0; clr = 1'b0; wr_mode = 1'b0; sw_data = '0;
    model_reset();

    // reset state
    apply_reset();
    chk("rst_ptr", 32'(ptr), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_pulses", {29'd0, rd_valid, wr_done, wrap}, 32'd0);

    // first edge after reset release ignores step
    tick(1'b1, 1'b0, 1'b1, 16'hBEEF);
    idle_ticks(4);
    chk("first_edge_ptr", 32'(ptr), 32'd0);
    chk("first_edge_pops", pops, 0);

    // single write
    do_access(1'b1, 16'hA5A5);
    chk("wr_ptr", 32'(ptr), 32'd1);
    chk("wr_pops", pops, 1);
    tick(1'b0, 1'b1, 1'b0, '0);
    idle_ticks(1);
    do_access(1'b0, '0);
    chk("mem0_readback", 32'(last_rd), 32'hA5A5);

    // two writes, clr, two reads
    apply_reset();
    idle_ticks(1);
    do_access(1'b1, 16'h1111);
    do_access(1'b1, 16'h2222);
    tick(1'b0, 1'b1, 1'b0, '0);
    idle_ticks(1);
    p0 = pops;
    do_access(1'b0, '0);
    chk("read1", 32'(last_rd), 32'h1111);
    do_access(1'b0, '0);
    chk("read2", 32'(last_rd), 32'h2222);
    chk("read_pulses", pops - p0, 2);

    // wrap after 16 writes
    apply_reset();
    idle_ticks(1);
    wrap_cnt = 0;
    for (int i = 0; i < 15; i++) do_access(1'b1, DW'($urandom));
    chk("wrap_early", wrap_cnt, 0);
    do_access(1'b1, DW'($urandom));
    chk("wrap_16th", wrap_cnt, 1);
    chk("wrap_ptr", 32'(ptr), 32'd0);

    // back-to-back step -> overrun, clr clears it
    apply_reset();
    idle_ticks(1);
    p0 = pops;
    tick(1'b1, 1'b0, 1'b1, 16'h0F0F);
    tick(1'b1, 1'b0, 1'b1, 16'hF0F0);
    idle_ticks(4);
    chk("ovr_accesses", pops - p0, 1);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    tick(1'b0, 1'b1, 1'b0, '0);
    idle_ticks(1);
    chk("ovr_clr", {31'd0, overrun}, 32'd0);
    chk("ovr_clr_ptr", 32'(ptr), 32'd0);

    // step + clr together at ptr=5
    for (int i = 0; i < 5; i++) do_access(1'b1, DW'($urandom));
    chk("ptr5", 32'(ptr), 32'd5);
    p0 = pops;
    tick(1'b1, 1'b1, 1'b1, 16'h5555);
    idle_ticks(4);
    chk("stepclr_ptr", 32'(ptr), 32'd0);
    chk("stepclr_ovr", {31'd0, overrun}, 32'd0);
    chk("stepclr_pops", pops - p0, 0);

    // randomized mix; gap 0 provokes overruns, clr lands anywhere
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) tick(1'b0, 1'b1, 1'b0, '0);
      else tick(1'b1, 1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
      idle_ticks($urandom_range(0, 4));
    end
    idle_ticks(4);
    chk("rand_ptr", 32'(ptr), 32'(m_ptr));
    chk("rand_ovr", {31'd0, overrun}, {31'd0, m_ovr});

    // reset during WRITE aborts the access
    apply_reset();
    idle_ticks(1);
    for (int i = 0; i < 3; i++) do_access(1'b1, DW'($urandom));
    tick(1'b1, 1'b0, 1'b1, 16'hCAFE);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_ptr", 32'(ptr), 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_outs", {13'd0, rd_data, rd_valid, wr_done, wrap}, 32'd0);
    apply_reset();
    idle_ticks(1);
    for (int i = 0; i < 4; i++) do_access(1'b0, '0);
    chk("midrst_mem3", 32'(last_rd), 32'd0);

    // drain with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle_ticks(1);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_step_ctrl.md
REGFILE_STEP_CTRL -- requirements
Module: regfile_step_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, register data width; ADDR_W, default 4, pointer width; DEPTH = 2**ADDR_W entries.
REQ-002 clk  input  1  system clock; same clock as the upstream debouncer.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 step  input  1  one-shot pulse from the debouncer; 1 = request one access.
REQ-005 clr  input  1  one-shot pulse; 1 = return the pointer to 0.
REQ-006 wr_mode  input  1  level switch; 1 = write access, 0 = read access; sampled on the step cycle.
REQ-007 sw_data  input  DATA_W  write data; sampled on the step cycle.
REQ-008 ptr  output  ADDR_W  current register pointer.
REQ-009 rd_data  output  DATA_W  last read value, held until the next read.
REQ-010 rd_valid  output  1  1-cycle pulse; 1 = rd_data updated this cycle.
REQ-011 wr_done  output  1  1-cycle pulse; 1 = write committed.
REQ-012 wrap  output  1  1-cycle pulse; 1 = pointer wrapped from DEPTH-1 to 0.
REQ-013 busy  output  1  1 = state is not IDLE.
REQ-014 overrun  output  1  sticky; 1 = a step was dropped.

Function
REQ-015 The FSM SHALL have the states IDLE, WRITE, READ and ADVANCE.
REQ-016 IDLE + step SHALL capture wr_mode and sw_data into registers, then go to WRITE if wr_mode=1 and to READ otherwise.
REQ-017 WRITE SHALL store the captured data at mem[ptr] and go to ADVANCE.
REQ-018 READ SHALL load rd_data <= mem[ptr] and go to ADVANCE.
REQ-019 ADVANCE SHALL set ptr <= (ptr+1) mod DEPTH, assert wr_done or rd_valid to match the access type, assert wrap if ptr was DEPTH-1, and go to IDLE.
REQ-020 Latency from step to wr_done/rd_valid SHALL be 3 clk cycles; the next step SHALL be accepted 3 cycles after the previous one.
REQ-021 A step received while busy=1 SHALL be discarded with no access, and SHALL set overrun.
REQ-022 clr in IDLE SHALL set ptr to 0 on the next edge, with no memory access and no wrap.
REQ-023 clr while busy SHALL let the current access finish on the old ptr; ADVANCE SHALL then load ptr=0 instead of ptr+1, and SHALL NOT assert wrap.
REQ-024 If step and clr arrive together in IDLE, clr SHALL win, step SHALL be discarded, and overrun SHALL remain unchanged.
REQ-025 overrun SHALL clear only when clr is accepted or on reset.
REQ-026 Memory contents SHALL change only in WRITE, one entry per access.
REQ-027 A read of an entry never written since reset SHALL return 0.

Reset
REQ-028 reset=0 SHALL, asynchronously: force IDLE; set ptr=0, rd_data=0, and rd_valid, wr_done, wrap, busy, overrun=0; clear all DEPTH memory entries to 0.
REQ-029 A reset in mid-access SHALL abort the access, with no write commit and no pulse output.
REQ-030 The block SHALL ignore step and clr on the first clk edge after reset is deasserted.

Structure
REQ-031 The state encoding and the DATA_W/ADDR_W defaults SHALL live in the shared package regfile_pkg.
REQ-032 The storage SHALL be one sub-module, regfile_mem, with asynchronous read, synchronous write and asynchronous clear-on-reset; the FSM and pointer SHALL live in regfile_step_ctrl.

Verification
REQ-033 Reset, then wr_mode=1, sw_data=16'hA5A5, one step -> wr_done 3 cycles later, ptr=1, mem[0]=16'hA5A5.
REQ-034 Write 16'h1111, 16'h2222, clr, wr_mode=0, two steps -> rd_data=16'h1111 then 16'h2222, each with one rd_valid pulse.
REQ-035 16 write steps from ptr=0 -> wrap pulses only on the 16th ADVANCE, and ptr=0 afterwards.
REQ-036 A second step 1 cycle after the first -> one access only, overrun=1; then clr -> overrun=0, ptr=0.
REQ-037 reset=0 during WRITE -> no wr_done, mem[ptr] stays 0, all outputs 0 within the same cycle.
REQ-038 step and clr in the same IDLE cycle at ptr=5 -> ptr=0, no access, overrun=0.
